// File: rtl/decoder_scan_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : decoder_scan_pkg
//  Description : Shared types and helpers for the decoder scan controller.
//                - scan_state_t : controller state encoding (IDLE/GAP/DRIVE)
//                - SEL_W        : width of the decoder select code
//                - MASK_W       : width of the optional skip mask
//                - cnt_width()  : width of the shared blank/dwell counter
//  Revision    : 1.0 - initial release
// ============================================================================
package decoder_scan_pkg;

    localparam int SEL_W  = 3;
    localparam int MASK_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GAP   = 2'd1,
        ST_DRIVE = 2'd2
    } scan_state_t;

    // One down-counter serves both the blanking and dwell phases. It is
    // loaded with (length - 1) and counts to zero, so it only has to hold
    // max(DWELL, BLANK) - 1.
    function automatic int cnt_width(input int dwell, input int blank);
        int m;
        m = (dwell > blank) ? dwell : blank;
        return (m <= 2) ? 1 : $clog2(m);
    endfunction

endpackage : decoder_scan_pkg
`default_nettype wire

// File: rtl/decoder_scan_next_idx.sv
`default_nettype none
// ============================================================================
//  Module      : decoder_scan_next_idx
//  Description : Combinational index finder for the scan controller.
//                Returns the next select index after cur_idx and the first
//                index of a sweep, each with a valid flag.
//                With DECODER_SCAN_SKIP_EN defined, masked indices are
//                skipped (priority search); otherwise it is a plain
//                increment with a terminal check against NUM_SEL.
//  Ports       : cur_idx     in   current select index
//                skip_mask   in   bit i = 1 skips index i (macro only)
//                next_idx    out  lowest scanned index above cur_idx
//                next_valid  out  next_idx exists below NUM_SEL
//                first_idx   out  lowest scanned index
//                first_valid out  at least one index is scanned
//  Revision    : 1.0 - initial release
// ============================================================================
module decoder_scan_next_idx
    import decoder_scan_pkg::*;
#(
    parameter int NUM_SEL = 8
)(
    input  logic [SEL_W-1:0]  cur_idx,
`ifdef DECODER_SCAN_SKIP_EN
    input  logic [MASK_W-1:0] skip_mask,
`endif
    output logic [SEL_W-1:0]  next_idx,
    output logic              next_valid,
    output logic [SEL_W-1:0]  first_idx,
    output logic              first_valid
);

`ifdef DECODER_SCAN_SKIP_EN

    // Descending walk so the lowest qualifying index is the last one written.
    always_comb begin
        next_idx    = '0;
        next_valid  = 1'b0;
        first_idx   = '0;
        first_valid = 1'b0;
        for (int i = NUM_SEL - 1; i >= 0; i--) begin
            if (!skip_mask[i]) begin
                first_idx   = SEL_W'(i);
                first_valid = 1'b1;
                if (i > int'(cur_idx)) begin
                    next_idx   = SEL_W'(i);
                    next_valid = 1'b1;
                end
            end
        end
    end

`else

    localparam logic [SEL_W:0] c_num_sel = (SEL_W + 1)'(NUM_SEL);
    localparam logic [SEL_W:0] c_one     = (SEL_W + 1)'(1);

    logic [SEL_W:0] w_inc;

    // One extra bit so an increment past 7 is still seen as terminal.
    assign w_inc       = {1'b0, cur_idx} + c_one;
    assign next_idx    = w_inc[SEL_W-1:0];
    assign next_valid  = (w_inc < c_num_sel);
    assign first_idx   = '0;
    assign first_valid = 1'b1;

`endif

endmodule : decoder_scan_next_idx
`default_nettype wire

// File: rtl/decoder_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : decoder_scan_ctrl
//  Description : Scan controller driving the select code and enable of a
//                3-to-8 decoder. Each select index gets BLANK enable-low
//                cycles followed by DWELL enable-high cycles. Single sweep
//                or continuous scanning with start/stop/done handshake.
//                Optional feature macro: DECODER_SCAN_SKIP_EN (adds the
//                skip_mask port; masked indices are not scanned).
//  Ports       : clk        in   rising-edge clock
//                rst_n      in   synchronous active-low reset
//                start      in   begin scanning (honoured only when idle)
//                stop       in   end scanning after the current dwell
//                cont       in   captured with start: 1 = continuous
//                skip_mask  in   bit i = 1 skips select i (macro only)
//                A, B, C    out  select code, A = MSB
//                en         out  decoder enable
//                busy       out  scan in progress
//                done       out  one-cycle pulse when scanning ends
//  Revision    : 1.0 - initial release
// ============================================================================
module decoder_scan_ctrl
    import decoder_scan_pkg::*;
#(
    parameter int DWELL   = 4,
    parameter int BLANK   = 1,
    parameter int NUM_SEL = 8
)(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              stop,
    input  logic              cont,
`ifdef DECODER_SCAN_SKIP_EN
    input  logic [MASK_W-1:0] skip_mask,
`endif
    output logic              A,
    output logic              B,
    output logic              C,
    output logic              en,
    output logic              busy,
    output logic              done
);

    localparam int CNT_W = cnt_width(DWELL, BLANK);

    localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_dwell_ld = CNT_W'(DWELL - 1);
    localparam logic [CNT_W-1:0] c_blank_ld = CNT_W'((BLANK > 0) ? (BLANK - 1) : 0);

    // With no blanking the GAP state is never visited: every new index
    // goes straight into its dwell window.
    localparam scan_state_t      c_entry_state = (BLANK > 0) ? ST_GAP : ST_DRIVE;
    localparam logic [CNT_W-1:0] c_entry_cnt   = (BLANK > 0) ? c_blank_ld : c_dwell_ld;

    scan_state_t      r_state;
    logic [SEL_W-1:0] r_idx;
    logic [CNT_W-1:0] r_cnt;
    logic             r_cont;
    logic             r_stop;
    logic             r_en;
    logic             r_busy;
    logic             r_done;

    scan_state_t      w_state_nxt;
    logic [SEL_W-1:0] w_idx_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_cont_nxt;
    logic             w_stop_nxt;
    logic             w_done_nxt;

    logic [SEL_W-1:0] w_next_idx;
    logic             w_next_valid;
    logic [SEL_W-1:0] w_first_idx;
    logic             w_first_valid;

    decoder_scan_next_idx #(
        .NUM_SEL     (NUM_SEL)
    ) u_next_idx (
        .cur_idx     (r_idx),
`ifdef DECODER_SCAN_SKIP_EN
        .skip_mask   (skip_mask),
`endif
        .next_idx    (w_next_idx),
        .next_valid  (w_next_valid),
        .first_idx   (w_first_idx),
        .first_valid (w_first_valid)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_cnt_nxt   = r_cnt;
        w_cont_nxt  = r_cont;
        w_stop_nxt  = r_stop;
        w_done_nxt  = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_stop_nxt = 1'b0;
                // A simultaneous stop cancels the start outright.
                if (start && !stop) begin
                    if (w_first_valid) begin
                        w_idx_nxt   = w_first_idx;
                        w_cont_nxt  = cont;
                        w_state_nxt = c_entry_state;
                        w_cnt_nxt   = c_entry_cnt;
                    end else begin
                        // Nothing to scan: finish immediately without busy.
                        w_done_nxt  = 1'b1;
                    end
                end
            end

            ST_GAP: begin
                if (stop) begin
                    w_stop_nxt = 1'b1;
                end
                if (r_cnt == '0) begin
                    w_state_nxt = ST_DRIVE;
                    w_cnt_nxt   = c_dwell_ld;
                end else begin
                    w_cnt_nxt   = r_cnt - c_cnt_one;
                end
            end

            ST_DRIVE: begin
                if (stop) begin
                    w_stop_nxt = 1'b1;
                end
                if (r_cnt != '0) begin
                    w_cnt_nxt = r_cnt - c_cnt_one;
                end else if (r_stop || stop) begin
                    // A stop arriving in the final dwell cycle still counts.
                    w_state_nxt = ST_IDLE;
                    w_done_nxt  = 1'b1;
                    w_stop_nxt  = 1'b0;
                end else if (w_next_valid) begin
                    w_idx_nxt   = w_next_idx;
                    w_state_nxt = c_entry_state;
                    w_cnt_nxt   = c_entry_cnt;
                end else if (r_cont && w_first_valid) begin
                    w_idx_nxt   = w_first_idx;
                    w_state_nxt = c_entry_state;
                    w_cnt_nxt   = c_entry_cnt;
                end else begin
                    w_state_nxt = ST_IDLE;
                    w_done_nxt  = 1'b1;
                    w_stop_nxt  = 1'b0;
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
                w_stop_nxt  = 1'b0;
            end
        endcase
    end

    // Outputs are registered from the next-state decode so they line up
    // with the state they describe.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
            r_cnt   <= '0;
            r_cont  <= 1'b0;
            r_stop  <= 1'b0;
            r_en    <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_cnt   <= w_cnt_nxt;
            r_cont  <= w_cont_nxt;
            r_stop  <= w_stop_nxt;
            r_en    <= (w_state_nxt == ST_DRIVE);
            r_busy  <= (w_state_nxt != ST_IDLE);
            r_done  <= w_done_nxt;
        end
    end

    assign A    = r_idx[2];
    assign B    = r_idx[1];
    assign C    = r_idx[0];
    assign en   = r_en;
    assign busy = r_busy;
    assign done = r_done;

endmodule : decoder_scan_ctrl
`default_nettype wire

// File: tb/tb_decoder_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_decoder_scan_ctrl
//  Description : Self-checking bench for decoder_scan_ctrl. Instance u_dut
//                uses default parameters and is followed cycle by cycle by a
//                queue-based reference model; u_dut2 uses BLANK=0, DWELL=1,
//                NUM_SEL=3. Honours DECODER_SCAN_SKIP_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_decoder_scan_ctrl;

    localparam int M_DWELL = 4;
    localparam int M_BLANK = 1;
    localparam int M_NUM   = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       cont = 1'b0;
    logic [7:0] skip_mask = 8'h00;
    logic       a, b, c, en, busy, done;

    logic       start2 = 1'b0;
    logic       stop2 = 1'b0;
    logic       cont2 = 1'b0;
    logic [7:0] skip_mask2 = 8'h00;
    logic       a2, b2, c2, en2, busy2, done2;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    decoder_scan_ctrl #(.DWELL(M_DWELL), .BLANK(M_BLANK), .NUM_SEL(M_NUM)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .cont(cont),
`ifdef DECODER_SCAN_SKIP_EN
        .skip_mask(skip_mask),
`endif
        .A(a), .B(b), .C(c), .en(en), .busy(busy), .done(done)
    );

    decoder_scan_ctrl #(.DWELL(1), .BLANK(0), .NUM_SEL(3)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .stop(stop2), .cont(cont2),
`ifdef DECODER_SCAN_SKIP_EN
        .skip_mask(skip_mask2),
`endif
        .A(a2), .B(b2), .C(c2), .en(en2), .busy(busy2), .done(done2)
    );

    task automatic chk(input string nm, input logic [31:0] act, input int exp);
        n_cmp++;
        if (act !== 32'(exp)) begin
            n_fail++;
            $display("FAIL %s @%0t: actual %0d required %0d", nm, $time, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // Each scanned index is a window of BLANK idle slots then DWELL enabled
    // slots; the model pops one slot per clock and chooses the next window
    // from the mask only when the current one has been used up.
    typedef struct { int sel; bit en; } slot_t;
    slot_t win[$];
    bit    m_valid = 0, m_active = 0, m_cont = 0, m_stop = 0;
    bit    m_busy = 0, m_en = 0, m_done = 0;
    int    m_sel = 0;

    function automatic int m_first(input logic [7:0] msk);
        for (int i = 0; i < M_NUM; i++) if (!msk[i]) return i;
        return -1;
    endfunction

    function automatic int m_next(input logic [7:0] msk, input int cur);
        for (int i = cur + 1; i < M_NUM; i++) if (!msk[i]) return i;
        return -1;
    endfunction

    task automatic load_window(input int idx);
        for (int k = 0; k < M_BLANK; k++) win.push_back('{sel: idx, en: 1'b0});
        for (int k = 0; k < M_DWELL; k++) win.push_back('{sel: idx, en: 1'b1});
    endtask

    always @(posedge clk) begin
        int    nx;
        slot_t s;
        m_done = 0;
        if (!rst_n) begin
            m_active = 0;
            win.delete();
        end else if (!m_active) begin
            if (start && !stop) begin
                nx = m_first(skip_mask);
                if (nx < 0) m_done = 1;
                else begin
                    m_active = 1; m_cont = cont; m_stop = 0;
                    load_window(nx);
                end
            end
        end else begin
            if (stop) m_stop = 1;
            if (win.size() == 0) begin
                nx = m_next(skip_mask, m_sel);
                if (m_stop) nx = -1;
                else if (nx < 0 && m_cont) nx = m_first(skip_mask);
                if (nx < 0) begin m_active = 0; m_done = 1; end
                else load_window(nx);
            end
        end
        if (m_active) begin
            s = win.pop_front();
            m_busy = 1; m_en = s.en; m_sel = s.sel;
        end else begin
            m_busy = 0; m_en = 0;
        end
        m_valid = 1;
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chk("model_busy", 32'(busy), int'(m_busy));
            chk("model_en",   32'(en),   int'(m_en));
            chk("model_done", 32'(done), int'(m_done));
            if (m_busy) chk("model_sel", 32'({a, b, c}), m_sel);
        end
    end

    // ---------------- directed stimulus ----------------
    typedef struct { int j; bit busy; bit en; int sel; bit done; } vec_t;
    vec_t tbl[11];

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk_pt(input string nm, input bit e_busy, input bit e_en,
                          input int e_sel, input bit e_done);
        chk({nm, "_busy"}, 32'(busy), int'(e_busy));
        chk({nm, "_en"},   32'(en),   int'(e_en));
        chk({nm, "_done"}, 32'(done), int'(e_done));
        if (e_sel >= 0) chk({nm, "_sel"}, 32'({a, b, c}), e_sel);
    endtask

    // Pulses start for one edge; afterwards the bench sits at observation j=1.
    task automatic pulse_start(input bit cm);
        start = 1'b1; cont = cm;
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        int j;

        // j = observation index after the start edge (j=1 is the first cycle)
        tbl[0]  = '{j: 1,  busy: 1, en: 0, sel: 0,  done: 0};
        tbl[1]  = '{j: 2,  busy: 1, en: 1, sel: 0,  done: 0};
        tbl[2]  = '{j: 5,  busy: 1, en: 1, sel: 0,  done: 0};
        tbl[3]  = '{j: 6,  busy: 1, en: 0, sel: 1,  done: 0};
        tbl[4]  = '{j: 7,  busy: 1, en: 1, sel: 1,  done: 0};
        tbl[5]  = '{j: 10, busy: 1, en: 1, sel: 1,  done: 0};
        tbl[6]  = '{j: 11, busy: 1, en: 0, sel: 2,  done: 0};
        tbl[7]  = '{j: 37, busy: 1, en: 1, sel: 7,  done: 0};
        tbl[8]  = '{j: 40, busy: 1, en: 1, sel: 7,  done: 0};
        tbl[9]  = '{j: 41, busy: 0, en: 0, sel: -1, done: 1};
        tbl[10] = '{j: 42, busy: 0, en: 0, sel: -1, done: 0};

        // Reset state
        step(3);
        chk_pt("reset", 0, 0, 0, 0);
        chk("reset2_busy", 32'(busy2), 0);
        chk("reset2_done", 32'(done2), 0);
        rst_n = 1'b1;
        step(2);

        // Default single sweep against the table
        pulse_start(1'b0);
        j = 1;
        for (int t = 0; t < 11; t++) begin
            while (j < tbl[t].j) begin @(negedge clk); j++; end
            chk_pt($sformatf("sweep_j%0d", tbl[t].j), tbl[t].busy, tbl[t].en,
                   tbl[t].sel, tbl[t].done);
        end
        step(2);

        // Continuous mode, stop mid-dwell at select 5
        pulse_start(1'b1);
        step(27);                          // j = 28
        chk_pt("cstop_j28", 1, 1, 5, 0);
        stop = 1'b1;
        @(negedge clk); stop = 1'b0;       // j = 29
        chk_pt("cstop_j29", 1, 1, 5, 0);
        step(1);
        chk_pt("cstop_j30", 1, 1, 5, 0);
        step(1);
        chk_pt("cstop_done", 0, 0, -1, 1);
        step(3);
        chk_pt("cstop_idle", 0, 0, -1, 0);

        // start + stop together in IDLE
        start = 1'b1; stop = 1'b1;
        @(negedge clk);
        start = 1'b0; stop = 1'b0;
        chk_pt("ss_j1", 0, 0, -1, 0);
        step(1);
        chk_pt("ss_j2", 0, 0, -1, 0);

        // start while busy does not restart the index
        pulse_start(1'b0);
        step(7);                           // j = 8
        start = 1'b1;
        @(negedge clk); start = 1'b0;      // j = 9
        step(1);
        chk_pt("rebusy_j10", 1, 1, 1, 0);
        step(1);
        chk_pt("rebusy_j11", 1, 0, 2, 0);
        step(30);
        chk_pt("rebusy_done", 0, 0, -1, 1);
        step(2);

        // Reset mid-DRIVE at select 3
        pulse_start(1'b0);
        step(17);                          // j = 18
        chk_pt("rst_pre", 1, 1, 3, 0);
        rst_n = 1'b0;
        step(1);
        chk_pt("rst_abort", 0, 0, 0, 0);
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step(1);
            chk_pt("rst_idle", 0, 0, -1, 0);
        end

        // BLANK=0, DWELL=1, NUM_SEL=3 instance
        start2 = 1'b1;
        @(negedge clk); start2 = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("d2_en_%0d", k),  32'(en2),  1);
            chk($sformatf("d2_sel_%0d", k), 32'({a2, b2, c2}), k);
            step(1);
        end
        chk("d2_done", 32'(done2), 1);
        chk("d2_busy", 32'(busy2), 0);
        step(1);
        chk("d2_done_end", 32'(done2), 0);

`ifdef DECODER_SCAN_SKIP_EN
        // Alternate mask: only 0, 2, 4, 6 are driven
        skip_mask = 8'b1010_1010;
        pulse_start(1'b0);
        chk_pt("mask_j1", 1, 0, 0, 0);
        step(2);  chk_pt("mask_j3",  1, 1, 0, 0);
        step(3);  chk_pt("mask_j6",  1, 0, 2, 0);
        step(7);  chk_pt("mask_j13", 1, 1, 4, 0);
        step(5);  chk_pt("mask_j18", 1, 1, 6, 0);
        step(3);  chk_pt("mask_done", 0, 0, -1, 1);
        step(2);

        // Fully masked: immediate done, no busy, no en
        skip_mask = 8'hFF;
        pulse_start(1'b0);
        chk_pt("full_j1", 0, 0, -1, 1);
        step(1);
        chk_pt("full_j2", 0, 0, -1, 0);
        skip_mask = 8'h00;
        step(2);
`endif

        // Randomized traffic, checked by the reference model
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            rst_n = ($urandom_range(0, 599) != 0);
            start = ($urandom_range(0, 7) == 0);
            stop  = ($urandom_range(0, 29) == 0);
            cont  = 1'($urandom_range(0, 1));
`ifdef DECODER_SCAN_SKIP_EN
            if ($urandom_range(0, 49) == 0) begin
                if ($urandom_range(0, 7) == 0) skip_mask = 8'hFF;
                else skip_mask = 8'($urandom & $urandom);
            end
`endif
        end
        start = 1'b0; stop = 1'b0;
        step(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule : tb_decoder_scan_ctrl
`default_nettype wire
